// File: rtl/lbr_pkg.sv
// Shared definitions for the Last Branch Record controller.
// Request codes, FSM encoding, control-word and status layout.
package lbr_pkg;

  localparam logic [1:0] LBR_READ  = 2'b10;
  localparam logic [1:0] LBR_WRITE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_RESP,
    ST_CLEAR
  } lbr_state_e;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_CLEAR  = 1;

  localparam int STAT_ENABLE    = 0;
  localparam int STAT_COUNT_LSB = 1;
  localparam int STAT_DROP_W    = 16;

  typedef enum logic {
    RSRC_RAM,
    RSRC_HOLD
  } rsp_src_e;

endpackage

// File: rtl/lbr_ram.sv
// Branch record storage: one write port, one registered read port.
// A same-edge read of the slot being written returns the old contents.
module lbr_ram #(
  parameter int DEPTH    = 16,
  parameter int WIDTH    = 64,
  parameter int IDX_BITS = 4
) (
  input  logic                clock,
  input  logic                we,
  input  logic [IDX_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]    wdata,
  input  logic                re,
  input  logic [IDX_BITS-1:0] raddr,
  output logic [WIDTH-1:0]    rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/lbr_controller.sv
// LBR controller: records retired taken branches in a circular buffer
// and serves RDLBR/WRLBR requests with a stalling req/rsp handshake.
module lbr_controller
  import lbr_pkg::*;
#(
  parameter int CORE         = 0,
  parameter int ADDRESS_BITS = 32,
  parameter int LBR_DEPTH    = 16,
  parameter int IDX_BITS     = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    branch_valid,
  input  logic [ADDRESS_BITS-1:0] branch_from_pc,
  input  logic [ADDRESS_BITS-1:0] branch_to_pc,
  input  logic                    req_valid,
  input  logic [1:0]              lbr_req,
  input  logic [ADDRESS_BITS-1:0] lbr_index,
  input  logic [ADDRESS_BITS-1:0] lbr_wdata,
  output logic                    req_ready,
  output logic                    rsp_valid,
  output logic [ADDRESS_BITS-1:0] rsp_data,
  output logic                    stall,
  input  logic                    report
);

  localparam int AB = ADDRESS_BITS;
  localparam int EW = 2 * ADDRESS_BITS;
  localparam logic [IDX_BITS:0]   FULL  = (IDX_BITS+1)'(LBR_DEPTH);
  localparam logic [IDX_BITS:0]   ONE_C = (IDX_BITS+1)'(1);
  localparam logic [IDX_BITS-1:0] ONE_I = IDX_BITS'(1);
  localparam logic [IDX_BITS-1:0] LAST  = IDX_BITS'(LBR_DEPTH - 1);

  lbr_state_e state_q, state_d;

  logic [IDX_BITS-1:0] head_q;
  logic [IDX_BITS:0]   count_q;
  logic [15:0]         dropped_q;
  logic                enable_q;
  logic [IDX_BITS-1:0] raddr_q;
  logic                field_q;
  logic                oob_q;
  rsp_src_e            src_q;
  logic [AB-1:0]       hold_q;
  logic [IDX_BITS-1:0] clr_q;
  logic [AB-1:0]       last_q;

  logic                accept, is_rd, is_wr, is_clr, is_ack;
  logic                rec, drop, in_clear;
  logic [IDX_BITS-1:0] rd_i;
  logic [AB-1:0]       status;
  logic [AB-1:0]       rsp_word;

  logic                ram_we, ram_re;
  logic [IDX_BITS-1:0] ram_waddr;
  logic [EW-1:0]       ram_wdata, ram_rdata;

  logic unused_bits;
  assign unused_bits = ^{lbr_index[AB-1:IDX_BITS+2],
                         lbr_wdata[AB-1:2]};

  assign in_clear = (state_q == ST_CLEAR);
  assign accept   = (state_q == ST_IDLE) && req_valid;
  assign is_rd    = accept && (lbr_req == LBR_READ);
  assign is_wr    = accept && (lbr_req == LBR_WRITE);
  assign is_clr   = is_wr && lbr_wdata[CTRL_CLEAR];
  assign is_ack   = accept && !is_rd && !is_clr;
  assign rd_i     = lbr_index[IDX_BITS-1:0];

  assign rec  = branch_valid && enable_q && !in_clear;
  assign drop = branch_valid && !rec;

  always_comb begin
    status = '0;
    status[STAT_ENABLE] = enable_q;
    status[STAT_COUNT_LSB +: IDX_BITS+1] = count_q;
    status[AB-1 -: STAT_DROP_W] = dropped_q;
  end

  assign ram_we    = rec || in_clear;
  assign ram_waddr = in_clear ? clr_q : head_q;
  assign ram_wdata = in_clear ? '0 : {branch_from_pc, branch_to_pc};
  assign ram_re    = (state_q == ST_READ);

  lbr_ram #(
    .DEPTH    (LBR_DEPTH),
    .WIDTH    (EW),
    .IDX_BITS (IDX_BITS)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (raddr_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      head_q    <= '0;
      count_q   <= '0;
      dropped_q <= '0;
      enable_q  <= 1'b1;
      raddr_q   <= '0;
      field_q   <= 1'b0;
      oob_q     <= 1'b0;
      src_q     <= RSRC_HOLD;
      hold_q    <= '0;
      clr_q     <= '0;
      last_q    <= '0;
    end else begin
      state_q <= state_d;
      if (rec) begin
        head_q <= head_q + ONE_I;
        if (count_q != FULL) count_q <= count_q + ONE_C;
      end
      if (drop && dropped_q != 16'hFFFF)
        dropped_q <= dropped_q + 16'd1;
      // Clearing the last slot wins over a same-cycle drop
      if (in_clear) begin
        clr_q <= clr_q + ONE_I;
        if (clr_q == LAST) begin
          head_q    <= '0;
          count_q   <= '0;
          dropped_q <= '0;
        end
      end
      if (is_rd) begin
        raddr_q <= head_q - ONE_I - rd_i;
        field_q <= lbr_index[IDX_BITS];
        oob_q   <= {1'b0, rd_i} >= count_q;
        src_q   <= lbr_index[IDX_BITS+1] ? RSRC_HOLD : RSRC_RAM;
        hold_q  <= status;
      end
      if (is_wr) begin
        enable_q <= lbr_wdata[CTRL_ENABLE];
        hold_q   <= AB'(enable_q);
        src_q    <= RSRC_HOLD;
        clr_q    <= '0;
      end
      if (accept && !is_rd && !is_wr) begin
        hold_q <= '0;
        src_q  <= RSRC_HOLD;
      end
      if (state_q == ST_RESP) last_q <= rsp_word;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        unique case (1'b1)
          is_rd:   state_d = ST_READ;
          is_clr:  state_d = ST_CLEAR;
          is_ack:  state_d = ST_RESP;
          default: state_d = ST_IDLE;
        endcase
      end
      ST_READ:  state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      ST_CLEAR: if (clr_q == LAST) state_d = ST_RESP;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rsp_word = '0;
    if (src_q == RSRC_HOLD)
      rsp_word = hold_q;
    else if (!oob_q)
      rsp_word = field_q ? ram_rdata[AB-1:0]
                         : ram_rdata[EW-1:AB];
  end

  always_comb begin
    req_ready = 1'b0;
    stall     = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    case (state_q)
      ST_IDLE: begin
        req_ready = req_valid && reset;
        stall     = req_valid && reset;
      end
      ST_READ:  stall = 1'b1;
      ST_CLEAR: stall = 1'b1;
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_data  = rsp_word;
      end
      default: ;
    endcase
  end

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (report)
      $display("lbr core%0d state=%s head=%0d count=%0d dropped=%0d en=%0b last=%h",
               CORE, state_q.name(), head_q, count_q, dropped_q,
               enable_q, last_q);
  end
`endif

endmodule

// File: tb/tb_lbr_controller.sv
// Directed bench for lbr_controller: recording, reads, writes,
// clear, same-cycle record/read and reset during a request.
module tb_lbr_controller;

  localparam logic [1:0] RD = 2'b10;
  localparam logic [1:0] WR = 2'b11;

  logic        clock;
  logic        reset;
  logic        branch_valid;
  logic [31:0] branch_from_pc;
  logic [31:0] branch_to_pc;
  logic        req_valid;
  logic [1:0]  lbr_req;
  logic [31:0] lbr_index;
  logic [31:0] lbr_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        stall;
  logic        report;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  lbr_controller #(
    .CORE(0), .ADDRESS_BITS(32), .LBR_DEPTH(16), .IDX_BITS(4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .branch_valid   (branch_valid),
    .branch_from_pc (branch_from_pc),
    .branch_to_pc   (branch_to_pc),
    .req_valid      (req_valid),
    .lbr_req        (lbr_req),
    .lbr_index      (lbr_index),
    .lbr_wdata      (lbr_wdata),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .stall          (stall),
    .report         (report)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] stat(input int d, input int c,
                                       input bit e);
    logic [31:0] dv, cv;
    dv = d;
    cv = c;
    return {dv[15:0], 10'b0, cv[4:0], e};
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic branch(input logic [31:0] f, input logic [31:0] t);
    branch_valid   = 1'b1;
    branch_from_pc = f;
    branch_to_pc   = t;
    tick();
    branch_valid = 1'b0;
  endtask

  task automatic xact(input logic [1:0] kind, input logic [31:0] arg,
                      input bit hold_br, output logic [31:0] data,
                      output int lat, output int stalls,
                      output logic acc_stall);
    req_valid = 1'b1;
    lbr_req   = kind;
    lbr_index = arg;
    lbr_wdata = arg;
    @(negedge clock);
    acc_stall = stall;
    chk("req_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    if (!hold_br) branch_valid = 1'b0;
    lat    = 0;
    stalls = 0;
    data   = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (rsp_valid) begin
        lat  = n;
        data = rsp_data;
        break;
      end
      if (stall) stalls++;
      tick();
    end
    if (lat != 0) tick();
  endtask

  task automatic rd(input string tag, input logic [31:0] idx,
                    input logic [31:0] exp);
    logic [31:0] d;
    int          l, s;
    logic        a;
    xact(RD, idx, 1'b0, d, l, s, a);
    chk(tag, d, exp);
  endtask

  initial begin
    logic [31:0] d;
    int          l, s, seen;
    logic        a;

    reset = 1'b0;
    branch_valid = 1'b0;
    branch_from_pc = '0;
    branch_to_pc = '0;
    req_valid = 1'b1;
    lbr_req = RD;
    lbr_index = '0;
    lbr_wdata = '0;
    report = 1'b0;

    repeat (2) tick();
    @(negedge clock);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    req_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // Three branches, then field/status reads
    branch(32'h100, 32'h200);
    branch(32'h104, 32'h300);
    branch(32'h108, 32'h400);
    xact(RD, 32'h0, 1'b0, d, l, s, a);
    chk("rd0_data", d, 32'h108);
    chk("rd0_lat", 32'(l), 32'd2);
    rd("rd12_to", 32'h12, 32'h200);
    rd("status_3", 32'h20, stat(0, 3, 1'b1));

    // Wrap-around
    for (int k = 0; k < 20; k++)
      branch(32'(k * 4), 32'h1000 + 32'(k * 4));
    rd("status_full", 32'h20, stat(0, 16, 1'b1));
    rd("rd15_oldest", 32'hF, 32'h10);
    rd("rd0_newest", 32'h0, 32'h4C);
    rd("rd1f_to", 32'h1F, 32'h1010);

    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // Out-of-range read with two entries
    branch(32'h500, 32'h600);
    branch(32'h504, 32'h700);
    xact(RD, 32'h5, 1'b0, d, l, s, a);
    chk("oob_data", d, 32'h0);
    chk("oob_lat", 32'(l), 32'd2);
    chk("oob_acc_stall", 32'(a), 32'd1);
    chk("oob_stalls", 32'(s), 32'd1);
    @(negedge clock);
    chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
    tick();
    rd("rd1_two", 32'h1, 32'h500);

    // Disable, drop, re-enable
    xact(WR, 32'h0, 1'b0, d, l, s, a);
    chk("wr0_old", d, 32'h1);
    chk("wr0_lat", 32'(l), 32'd1);
    chk("wr0_stalls", 32'(s), 32'd0);
    branch(32'h800, 32'h900);
    branch(32'h810, 32'h910);
    rd("status_dis", 32'h20, stat(2, 2, 1'b0));
    xact(WR, 32'h1, 1'b0, d, l, s, a);
    chk("wr1_old", d, 32'h0);
    chk("wr1_lat", 32'(l), 32'd1);

    // Clear with branch_valid held high throughout
    branch_valid   = 1'b1;
    branch_from_pc = 32'h900;
    branch_to_pc   = 32'h990;
    xact(WR, 32'h3, 1'b1, d, l, s, a);
    branch_valid = 1'b0;
    chk("clr_lat", 32'(l), 32'd17);
    chk("clr_stalls", 32'(s), 32'd16);
    rd("status_clr", 32'h20, stat(0, 1, 1'b1));
    rd("clr_resume", 32'h0, 32'h900);
    rd("clr_oob", 32'h1, 32'h0);

    // Branch and read accepted in the same cycle
    branch_valid   = 1'b1;
    branch_from_pc = 32'hA00;
    branch_to_pc   = 32'hA10;
    xact(RD, 32'h0, 1'b0, d, l, s, a);
    chk("same_cycle_old", d, 32'h900);
    rd("same_cycle_new", 32'h0, 32'hA00);

    report = 1'b1;
    tick();
    report = 1'b0;

    // Reset while in READ
    req_valid = 1'b1;
    lbr_req   = RD;
    lbr_index = 32'h0;
    tick();
    req_valid = 1'b0;
    @(negedge clock);
    chk("in_read_stall", 32'(stall), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_rsp_data", rsp_data, 32'd0);
    seen = 0;
    for (int n = 0; n < 3; n++) begin
      tick();
      if (rsp_valid) seen++;
    end
    reset = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      if (rsp_valid) seen++;
    end
    chk("no_rsp_after_rst", 32'(seen), 32'd0);
    rd("status_rst", 32'h20, stat(0, 0, 1'b1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
